// File: rtl/mem_read_arbiter_if.sv
// mem_read_arbiter_if
//   Bundles every handshake and bus signal around mem_read_arbiter. The
//   instruction-fetch side (i_*), the data side (d_*), the shared AXI read
//   channel (m_ar*, m_r*) and the monitored write-channel handshakes
//   (m_aw*, m_b*) all live here. The debug fields expose FSM state and the
//   internal counters.
//
//   Valid/ready rule on every channel: a transfer happens in the cycle where
//   valid and ready are both high at the rising clock edge. Once a source
//   raises valid, it holds valid and payload stable until that transfer.
//
//   Modports:
//     master : the arbiter's view. It drives m_ar*, m_rready, the requester
//              arready/rvalid signals, busy and the debug fields.
//     slave  : the environment's view (requesters, memory, write monitor).
interface mem_read_arbiter_if;
   logic [31:0] i_araddr;
   logic [7:0]  i_arlen;
   logic        i_arvalid;
   logic        i_arready;
   logic        i_rvalid;
   logic        i_rready;

   logic [31:0] d_araddr;
   logic [7:0]  d_arlen;
   logic [2:0]  d_arsize;
   logic        d_arvalid;
   logic        d_arready;
   logic        d_rvalid;
   logic        d_rready;

   logic [31:0] m_araddr;
   logic [7:0]  m_arlen;
   logic [2:0]  m_arsize;
   logic [3:0]  m_arid;
   logic        m_arvalid;
   logic        m_arready;
   logic        m_rlast;
   logic        m_rvalid;
   logic        m_rready;

   logic        m_awvalid;
   logic        m_awready;
   logic        m_bvalid;
   logic        m_bready;

   logic        busy;

   // Debug fields.
   // dbg_state encodes the FSM as follows: 0 IDLE, 1 AR_I, 2 R_I, 3 AR_D, 4 R_D.
   logic [2:0]  dbg_state;
   logic [7:0]  dbg_starve_cnt;
   logic [7:0]  dbg_wr_cnt;

   modport master (
      input  i_araddr, i_arlen, i_arvalid, i_rready,
      input  d_araddr, d_arlen, d_arsize, d_arvalid, d_rready,
      input  m_arready, m_rlast, m_rvalid,
      input  m_awvalid, m_awready, m_bvalid, m_bready,
      output i_arready, i_rvalid, d_arready, d_rvalid,
      output m_araddr, m_arlen, m_arsize, m_arid, m_arvalid, m_rready,
      output busy, dbg_state, dbg_starve_cnt, dbg_wr_cnt
   );

   modport slave (
      output i_araddr, i_arlen, i_arvalid, i_rready,
      output d_araddr, d_arlen, d_arsize, d_arvalid, d_rready,
      output m_arready, m_rlast, m_rvalid,
      output m_awvalid, m_awready, m_bvalid, m_bready,
      input  i_arready, i_rvalid, d_arready, d_rvalid,
      input  m_araddr, m_arlen, m_arsize, m_arid, m_arvalid, m_rready,
      input  busy, dbg_state, dbg_starve_cnt, dbg_wr_cnt
   );
endinterface

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter
//   Shares one AXI read channel between instruction fetch (i_*) and the
//   data side (d_*). Only one burst runs at a time. A granted side owns the
//   channel from its AR handshake until the R beat that carries rlast.
//
//   Arbitration rules:
//   - Data has priority over instruction.
//   - Data may only win while no write is outstanding.
//   - An instruction request that has lost STARVE_LIMIT times in a row is
//     forced to win.
//
//   rdata and rlast go straight from memory to both requesters. They are
//   not routed through this block.
//
//   Ports:
//     clk : clock
//     rst : synchronous, active-high reset
//     bus : mem_read_arbiter_if.master, carrying all request, AXI and
//           write-monitor signals, plus busy and the debug fields
module mem_read_arbiter #(
   parameter int STARVE_LIMIT = 8,
   parameter int WR_CNT_W     = 3
) (
   input logic               clk,
   input logic               rst,
   mem_read_arbiter_if.master bus
);
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      AR_I = 3'd1,
      R_I  = 3'd2,
      AR_D = 3'd3,
      R_D  = 3'd4
   } state_t;

   localparam int SC_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

   state_t              state;
   logic [SC_W-1:0]     starve_cnt;
   logic [WR_CNT_W-1:0] wr_cnt;

   logic d_elig, force_i, aw_hs, b_hs, ar_hs, rlast_hs;

   always_comb begin
      d_elig   = bus.d_arvalid && (wr_cnt == '0);
      force_i  = (starve_cnt == SC_MAX) && bus.i_arvalid;
      aw_hs    = bus.m_awvalid && bus.m_awready;
      b_hs     = bus.m_bvalid && bus.m_bready;
      ar_hs    = bus.m_arvalid && bus.m_arready;
      rlast_hs = bus.m_rvalid && bus.m_rready && bus.m_rlast;
   end

   // The ready/valid pass-throughs are gated by registered state. Because of
   // that, they are all 0 in IDLE, and therefore also right after reset.
   always_comb begin
      bus.i_arready = (state == AR_I) && bus.m_arready;
      bus.d_arready = (state == AR_D) && bus.m_arready;
      bus.i_rvalid  = (state == R_I) && bus.m_rvalid;
      bus.d_rvalid  = (state == R_D) && bus.m_rvalid;
      bus.m_rready  = 1'b0;
      if (state == R_I) bus.m_rready = bus.i_rready;
      if (state == R_D) bus.m_rready = bus.d_rready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         starve_cnt    <= '0;
         bus.m_araddr  <= '0;
         bus.m_arlen   <= '0;
         bus.m_arsize  <= '0;
         bus.m_arid    <= '0;
         bus.m_arvalid <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (force_i || (!d_elig && bus.i_arvalid)) begin
                  state         <= AR_I;
                  bus.m_araddr  <= bus.i_araddr;
                  bus.m_arlen   <= bus.i_arlen;
                  bus.m_arsize  <= 3'b010;
                  bus.m_arid    <= 4'd0;
                  bus.m_arvalid <= 1'b1;
                  bus.busy      <= 1'b1;
               end else if (d_elig) begin
                  state         <= AR_D;
                  bus.m_araddr  <= bus.d_araddr;
                  bus.m_arlen   <= bus.d_arlen;
                  bus.m_arsize  <= bus.d_arsize;
                  bus.m_arid    <= 4'd1;
                  bus.m_arvalid <= 1'b1;
                  bus.busy      <= 1'b1;
                  // Each lost arbitration counts toward the starvation override.
                  if (bus.i_arvalid && starve_cnt != SC_MAX)
                     starve_cnt <= starve_cnt + SC_W'(1);
               end
            end
            AR_I: begin
               if (ar_hs) begin
                  state         <= R_I;
                  bus.m_arvalid <= 1'b0;
                  starve_cnt    <= '0;
               end
            end
            AR_D: begin
               if (ar_hs) begin
                  state         <= R_D;
                  bus.m_arvalid <= 1'b0;
               end
            end
            R_I, R_D: begin
               if (rlast_hs) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            end
            default: begin
               state         <= IDLE;
               bus.m_arvalid <= 1'b0;
               bus.busy      <= 1'b0;
            end
         endcase
      end
   end

   // Outstanding-write counter. The counter saturates at all-ones and never
   // goes below zero. When an AW handshake and a B handshake land in the
   // same cycle, they cancel out.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt <= '0;
      end else if (aw_hs && !b_hs) begin
         assert (wr_cnt != '1);
         if (wr_cnt != '1) wr_cnt <= wr_cnt + WR_CNT_W'(1);
      end else if (b_hs && !aw_hs) begin
         assert (wr_cnt != '0);
         if (wr_cnt != '0) wr_cnt <= wr_cnt - WR_CNT_W'(1);
      end
   end

   always_comb begin
      bus.dbg_state      = state;
      bus.dbg_starve_cnt = 8'(starve_cnt);
      bus.dbg_wr_cnt     = 8'(wr_cnt);
   end
endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb_mem_read_arbiter
//   Directed bench for mem_read_arbiter. Each scenario task drives its
//   stimulus and compares the DUT outputs against values worked out by hand.
//
//   Timing: inputs are driven at posedge+1. Outputs are sampled at posedge+1,
//   before new inputs are applied, or after a further #1 where a
//   combinational path is being observed.
module tb_mem_read_arbiter;
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_AR_I = 3'd1;
   localparam logic [2:0] S_R_I  = 3'd2;
   localparam logic [2:0] S_AR_D = 3'd3;
   localparam logic [2:0] S_R_D  = 3'd4;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   mem_read_arbiter_if bus ();

   mem_read_arbiter #(.STARVE_LIMIT(8), .WR_CNT_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock and watchdog.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // Driver tasks.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.i_araddr = '0; bus.i_arlen = '0; bus.i_arvalid = 1'b0; bus.i_rready = 1'b0;
      bus.d_araddr = '0; bus.d_arlen = '0; bus.d_arsize = '0; bus.d_arvalid = 1'b0;
      bus.d_rready = 1'b0;
      bus.m_arready = 1'b0; bus.m_rlast = 1'b0; bus.m_rvalid = 1'b0;
      bus.m_awvalid = 1'b0; bus.m_awready = 1'b0; bus.m_bvalid = 1'b0; bus.m_bready = 1'b0;
   endtask

   // Plays n R beats, with rlast on the last one. For each beat it counts
   // which side saw it, and in how many beats busy was low.
   task automatic run_beats(input int n, output int i_seen, output int d_seen,
                            output int busy_low);
      i_seen = 0; d_seen = 0; busy_low = 0;
      for (int b = 0; b < n; b++) begin
         bus.m_rvalid = 1'b1;
         bus.m_rlast  = (b == n - 1);
         #1;
         if (bus.i_rvalid && !bus.d_rvalid && bus.m_rready) i_seen++;
         if (bus.d_rvalid && !bus.i_rvalid && bus.m_rready) d_seen++;
         if (!bus.busy) busy_low++;
         tick();
      end
      bus.m_rvalid = 1'b0;
      bus.m_rlast  = 1'b0;
   endtask

   // Scenario tasks.
   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      total++; if (bus.dbg_state !== S_IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=0", bus.dbg_state); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", bus.busy); end
      total++; if (bus.m_arvalid !== 1'b0) begin bad++; $display("FAIL rst_arvalid got=%0b exp=0", bus.m_arvalid); end
      total++; if (bus.m_araddr !== 32'h0) begin bad++; $display("FAIL rst_araddr got=%0h exp=0", bus.m_araddr); end
      total++; if (bus.dbg_wr_cnt !== 8'd0) begin bad++; $display("FAIL rst_wr_cnt got=%0d exp=0", bus.dbg_wr_cnt); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_instr_only();
      int is, ds, bl;
      bus.i_araddr = 32'hBFC0_0000; bus.i_arlen = 8'd7; bus.i_arvalid = 1'b1; bus.i_rready = 1'b1;
      tick();
      total++; if (bus.m_arvalid !== 1'b1) begin bad++; $display("FAIL t1_arvalid got=%0b exp=1", bus.m_arvalid); end
      total++; if (bus.m_arid !== 4'd0) begin bad++; $display("FAIL t1_arid got=%0d exp=0", bus.m_arid); end
      total++; if (bus.m_arsize !== 3'd2) begin bad++; $display("FAIL t1_arsize got=%0d exp=2", bus.m_arsize); end
      total++; if (bus.m_araddr !== 32'hBFC0_0000) begin bad++; $display("FAIL t1_araddr got=%0h exp=bfc00000", bus.m_araddr); end
      total++; if (bus.m_arlen !== 8'd7) begin bad++; $display("FAIL t1_arlen got=%0d exp=7", bus.m_arlen); end
      total++; if (bus.i_arready !== 1'b0) begin bad++; $display("FAIL t1_arready_lo got=%0b exp=0", bus.i_arready); end
      bus.m_arready = 1'b1;
      #1;
      total++; if (bus.i_arready !== 1'b1) begin bad++; $display("FAIL t1_arready_hi got=%0b exp=1", bus.i_arready); end
      tick();
      bus.i_arvalid = 1'b0; bus.m_arready = 1'b0;
      total++; if (bus.dbg_state !== S_R_I) begin bad++; $display("FAIL t1_state_r got=%0d exp=2", bus.dbg_state); end
      total++; if (bus.m_arvalid !== 1'b0) begin bad++; $display("FAIL t1_arvalid_drop got=%0b exp=0", bus.m_arvalid); end
      run_beats(8, is, ds, bl);
      total++; if (is !== 8) begin bad++; $display("FAIL t1_i_beats got=%0d exp=8", is); end
      total++; if (ds !== 0) begin bad++; $display("FAIL t1_d_beats got=%0d exp=0", ds); end
      total++; if (bl !== 0) begin bad++; $display("FAIL t1_busy_beats got=%0d exp=0", bl); end
      total++; if (bus.dbg_state !== S_IDLE) begin bad++; $display("FAIL t1_idle got=%0d exp=0", bus.dbg_state); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL t1_busy_end got=%0b exp=0", bus.busy); end
   endtask

   task automatic test_data_priority();
      int is, ds, bl;
      bus.i_araddr = 32'h1000_0040; bus.i_arlen = 8'd1; bus.i_arvalid = 1'b1;
      bus.d_araddr = 32'h2000_0080; bus.d_arlen = 8'd3; bus.d_arsize = 3'd3; bus.d_arvalid = 1'b1;
      bus.m_arready = 1'b1; bus.i_rready = 1'b1; bus.d_rready = 1'b1;
      tick();
      total++; if (bus.dbg_state !== S_AR_D) begin bad++; $display("FAIL t2_state got=%0d exp=3", bus.dbg_state); end
      total++; if (bus.m_arid !== 4'd1) begin bad++; $display("FAIL t2_arid got=%0d exp=1", bus.m_arid); end
      total++; if (bus.m_arsize !== 3'd3) begin bad++; $display("FAIL t2_arsize got=%0d exp=3", bus.m_arsize); end
      total++; if (bus.m_araddr !== 32'h2000_0080) begin bad++; $display("FAIL t2_araddr got=%0h exp=20000080", bus.m_araddr); end
      total++; if (bus.d_arready !== 1'b1) begin bad++; $display("FAIL t2_d_arready got=%0b exp=1", bus.d_arready); end
      total++; if (bus.i_arready !== 1'b0) begin bad++; $display("FAIL t2_i_arready got=%0b exp=0", bus.i_arready); end
      total++; if (bus.dbg_starve_cnt !== 8'd1) begin bad++; $display("FAIL t2_starve got=%0d exp=1", bus.dbg_starve_cnt); end
      tick();
      bus.d_arvalid = 1'b0;
      run_beats(4, is, ds, bl);
      total++; if (ds !== 4) begin bad++; $display("FAIL t2_d_beats got=%0d exp=4", ds); end
      total++; if (is !== 0) begin bad++; $display("FAIL t2_i_beats got=%0d exp=0", is); end
      total++; if (bus.m_arvalid !== 1'b0) begin bad++; $display("FAIL t2_no_b2b got=%0b exp=0", bus.m_arvalid); end
      tick();
      total++; if (bus.m_arvalid !== 1'b1) begin bad++; $display("FAIL t2_i_arvalid got=%0b exp=1", bus.m_arvalid); end
      total++; if (bus.m_arid !== 4'd0) begin bad++; $display("FAIL t2_i_arid got=%0d exp=0", bus.m_arid); end
      total++; if (bus.m_araddr !== 32'h1000_0040) begin bad++; $display("FAIL t2_i_araddr got=%0h exp=10000040", bus.m_araddr); end
      tick();
      bus.i_arvalid = 1'b0;
      total++; if (bus.dbg_starve_cnt !== 8'd0) begin bad++; $display("FAIL t2_starve_clr got=%0d exp=0", bus.dbg_starve_cnt); end
      run_beats(2, is, ds, bl);
      total++; if (is !== 2) begin bad++; $display("FAIL t2_i_beats2 got=%0d exp=2", is); end
   endtask

   task automatic test_starvation();
      int n_d;
      bit got_i;
      n_d = 0; got_i = 1'b0;
      bus.i_araddr = 32'h0000_1000; bus.i_arlen = 8'd0; bus.i_arvalid = 1'b1;
      bus.d_araddr = 32'h0000_2000; bus.d_arlen = 8'd0; bus.d_arsize = 3'd2; bus.d_arvalid = 1'b1;
      bus.m_arready = 1'b1; bus.m_rvalid = 1'b1; bus.m_rlast = 1'b1;
      for (int c = 0; c < 100 && !got_i; c++) begin
         if (bus.m_arvalid) begin
            if (bus.m_arid == 4'd1) n_d++;
            else got_i = 1'b1;
         end
         tick();
      end
      total++; if (got_i !== 1'b1) begin bad++; $display("FAIL t3_i_granted got=%0b exp=1", got_i); end
      total++; if (n_d !== 8) begin bad++; $display("FAIL t3_data_wins got=%0d exp=8", n_d); end
      total++; if (bus.dbg_state !== S_R_I) begin bad++; $display("FAIL t3_state got=%0d exp=2", bus.dbg_state); end
      total++; if (bus.dbg_starve_cnt !== 8'd0) begin bad++; $display("FAIL t3_starve_clr got=%0d exp=0", bus.dbg_starve_cnt); end
      total++; if (bus.i_rvalid !== 1'b1) begin bad++; $display("FAIL t3_i_rvalid got=%0b exp=1", bus.i_rvalid); end
      bus.i_arvalid = 1'b0; bus.d_arvalid = 1'b0;
      tick();
      bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0;
      total++; if (bus.dbg_state !== S_IDLE) begin bad++; $display("FAIL t3_idle got=%0d exp=0", bus.dbg_state); end
   endtask

   task automatic test_write_block();
      int is, ds, bl;
      bus.m_awvalid = 1'b1; bus.m_awready = 1'b1;
      tick();
      bus.m_awvalid = 1'b0; bus.m_awready = 1'b0;
      total++; if (bus.dbg_wr_cnt !== 8'd1) begin bad++; $display("FAIL t4_wr_inc got=%0d exp=1", bus.dbg_wr_cnt); end
      bus.i_araddr = 32'h3000_0000; bus.i_arlen = 8'd1; bus.i_arvalid = 1'b1;
      bus.d_araddr = 32'h4000_0000; bus.d_arlen = 8'd0; bus.d_arsize = 3'd2; bus.d_arvalid = 1'b1;
      bus.m_arready = 1'b1;
      tick();
      total++; if (bus.dbg_state !== S_AR_I) begin bad++; $display("FAIL t4_i_first got=%0d exp=1", bus.dbg_state); end
      total++; if (bus.d_arready !== 1'b0) begin bad++; $display("FAIL t4_d_arready got=%0b exp=0", bus.d_arready); end
      tick();
      bus.i_arvalid = 1'b0;
      run_beats(2, is, ds, bl);
      total++; if (is !== 2) begin bad++; $display("FAIL t4_i_beats got=%0d exp=2", is); end
      tick();
      total++; if (bus.dbg_state !== S_IDLE) begin bad++; $display("FAIL t4_d_held got=%0d exp=0", bus.dbg_state); end
      bus.m_bvalid = 1'b1; bus.m_bready = 1'b1;
      tick();
      bus.m_bvalid = 1'b0; bus.m_bready = 1'b0;
      total++; if (bus.dbg_wr_cnt !== 8'd0) begin bad++; $display("FAIL t4_wr_dec got=%0d exp=0", bus.dbg_wr_cnt); end
      total++; if (bus.m_arvalid !== 1'b0) begin bad++; $display("FAIL t4_b_cycle got=%0b exp=0", bus.m_arvalid); end
      tick();
      total++; if (bus.m_arvalid !== 1'b1) begin bad++; $display("FAIL t4_d_ar got=%0b exp=1", bus.m_arvalid); end
      total++; if (bus.m_arid !== 4'd1) begin bad++; $display("FAIL t4_d_arid got=%0d exp=1", bus.m_arid); end
      tick();
      bus.d_arvalid = 1'b0;
      run_beats(1, is, ds, bl);
      total++; if (ds !== 1) begin bad++; $display("FAIL t4_d_beats got=%0d exp=1", ds); end
   endtask

   task automatic test_aw_b_same_cycle();
      int is, ds, bl;
      bus.m_awvalid = 1'b1; bus.m_awready = 1'b1;
      tick();
      bus.m_bvalid = 1'b1; bus.m_bready = 1'b1;
      bus.d_araddr = 32'h5000_0000; bus.d_arlen = 8'd0; bus.d_arsize = 3'd1; bus.d_arvalid = 1'b1;
      bus.m_arready = 1'b1;
      tick();
      bus.m_awvalid = 1'b0; bus.m_awready = 1'b0; bus.m_bvalid = 1'b0; bus.m_bready = 1'b0;
      total++; if (bus.dbg_wr_cnt !== 8'd1) begin bad++; $display("FAIL t5_wr_same got=%0d exp=1", bus.dbg_wr_cnt); end
      total++; if (bus.dbg_state !== S_IDLE) begin bad++; $display("FAIL t5_blocked got=%0d exp=0", bus.dbg_state); end
      tick();
      total++; if (bus.m_arvalid !== 1'b0) begin bad++; $display("FAIL t5_blocked2 got=%0b exp=0", bus.m_arvalid); end
      bus.m_bvalid = 1'b1; bus.m_bready = 1'b1;
      tick();
      bus.m_bvalid = 1'b0; bus.m_bready = 1'b0;
      total++; if (bus.dbg_wr_cnt !== 8'd0) begin bad++; $display("FAIL t5_wr_zero got=%0d exp=0", bus.dbg_wr_cnt); end
      tick();
      total++; if (bus.dbg_state !== S_AR_D) begin bad++; $display("FAIL t5_d_grant got=%0d exp=3", bus.dbg_state); end
      total++; if (bus.m_arsize !== 3'd1) begin bad++; $display("FAIL t5_arsize got=%0d exp=1", bus.m_arsize); end
      tick();
      bus.d_arvalid = 1'b0;
      run_beats(1, is, ds, bl);
      total++; if (ds !== 1) begin bad++; $display("FAIL t5_d_beats got=%0d exp=1", ds); end
   endtask

   task automatic test_reset_mid_burst();
      int is, ds, bl;
      bus.d_araddr = 32'h6000_0000; bus.d_arlen = 8'd7; bus.d_arsize = 3'd2; bus.d_arvalid = 1'b1;
      bus.m_arready = 1'b1; bus.d_rready = 1'b1;
      tick();
      tick();
      bus.d_arvalid = 1'b0;
      bus.m_awvalid = 1'b1; bus.m_awready = 1'b1;
      bus.m_rvalid = 1'b1; bus.m_rlast = 1'b0;
      tick();
      bus.m_awvalid = 1'b0; bus.m_awready = 1'b0;
      tick();
      total++; if (bus.dbg_state !== S_R_D) begin bad++; $display("FAIL t6_pre_state got=%0d exp=4", bus.dbg_state); end
      total++; if (bus.dbg_wr_cnt !== 8'd1) begin bad++; $display("FAIL t6_pre_wr got=%0d exp=1", bus.dbg_wr_cnt); end
      rst = 1'b1;
      tick();
      total++; if (bus.dbg_state !== S_IDLE) begin bad++; $display("FAIL t6_state got=%0d exp=0", bus.dbg_state); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL t6_busy got=%0b exp=0", bus.busy); end
      total++; if (bus.d_rvalid !== 1'b0) begin bad++; $display("FAIL t6_d_rvalid got=%0b exp=0", bus.d_rvalid); end
      total++; if (bus.m_rready !== 1'b0) begin bad++; $display("FAIL t6_rready got=%0b exp=0", bus.m_rready); end
      total++; if (bus.m_araddr !== 32'h0) begin bad++; $display("FAIL t6_araddr got=%0h exp=0", bus.m_araddr); end
      total++; if (bus.m_arid !== 4'd0) begin bad++; $display("FAIL t6_arid got=%0d exp=0", bus.m_arid); end
      total++; if (bus.m_arsize !== 3'd0) begin bad++; $display("FAIL t6_arsize got=%0d exp=0", bus.m_arsize); end
      total++; if (bus.m_arlen !== 8'd0) begin bad++; $display("FAIL t6_arlen got=%0d exp=0", bus.m_arlen); end
      total++; if (bus.dbg_wr_cnt !== 8'd0) begin bad++; $display("FAIL t6_wr got=%0d exp=0", bus.dbg_wr_cnt); end
      rst = 1'b0;
      bus.m_rvalid = 1'b0;
      bus.i_araddr = 32'hBFC0_0100; bus.i_arlen = 8'd0; bus.i_arvalid = 1'b1; bus.i_rready = 1'b1;
      tick();
      total++; if (bus.m_arvalid !== 1'b1) begin bad++; $display("FAIL t6_new_ar got=%0b exp=1", bus.m_arvalid); end
      total++; if (bus.m_araddr !== 32'hBFC0_0100) begin bad++; $display("FAIL t6_new_addr got=%0h exp=bfc00100", bus.m_araddr); end
      tick();
      bus.i_arvalid = 1'b0;
      run_beats(1, is, ds, bl);
      total++; if (is !== 1) begin bad++; $display("FAIL t6_i_beats got=%0d exp=1", is); end
      total++; if (bus.dbg_state !== S_IDLE) begin bad++; $display("FAIL t6_end got=%0d exp=0", bus.dbg_state); end
   endtask

   // Sequence and final report.
   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      clear_inputs();
      test_reset();
      test_instr_only();
      test_data_priority();
      test_starvation();
      test_write_block();
      test_aw_b_same_cycle();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
- Shares the single AXI read channel of the memory interface between the instruction-fetch side (i_) and the data-side arbiter output (d_).
- Runs one burst at a time. A granted requester owns the channel from its AR handshake until the R beat with rlast.
- Fixed priority is data over instruction, with an anti-starvation override.
- Monitors the shared write channel so a data read never overtakes an outstanding write.

Parameters:
STARVE_LIMIT, 8, consecutive cycles a pending instruction request may lose before it is forced to win.
WR_CNT_W, 3, width of the outstanding-write counter.

Ports:
clk  in  1  clock
rst  in  1  reset
i_araddr  in  32  instruction read address
i_arlen  in  8  instruction burst length-1
i_arvalid  in  1  instruction request
i_arready  out  1  instruction address accepted
i_rvalid  out  1  R beat valid for instruction side
i_rready  in  1  instruction side ready
d_araddr  in  32  data read address
d_arlen  in  8  data burst length-1
d_arsize  in  3  data beat size
d_arvalid  in  1  data request
d_arready  out  1  data address accepted
d_rvalid  out  1  R beat valid for data side
d_rready  in  1  data side ready
m_araddr  out  32  AXI araddr
m_arlen  out  8  AXI arlen
m_arsize  out  3  AXI arsize
m_arid  out  4  0 = instruction, 1 = data
m_arvalid  out  1  AXI arvalid
m_arready  in  1  AXI arready
m_rlast  in  1  AXI rlast
m_rvalid  in  1  AXI rvalid
m_rready  out  1  AXI rready
m_awvalid  in  1  monitored write address valid
m_awready  in  1  monitored write address ready
m_bvalid  in  1  monitored write response valid
m_bready  in  1  monitored write response ready
busy  out  1  FSM not IDLE

Behaviour:
- Interface: single clock clk. Reset rst is synchronous and active-high.
- rdata and rlast are wired directly from the memory to both requesters and do not pass through this block.
- FSM states: IDLE, AR_I, R_I, AR_D, R_D.
- Reset (any cycle, including mid-burst):
  - state = IDLE, starve_cnt = 0, wr_cnt = 0.
  - All outputs 0; m_araddr, m_arlen, m_arsize, m_arid = 0.
  - Any in-flight burst is abandoned; the system reset clears the slave too.
- Data eligibility: d_elig = d_arvalid && wr_cnt == 0.
- IDLE selection:
  - If starve_cnt == STARVE_LIMIT and i_arvalid, go to AR_I.
  - Else if d_elig, go to AR_D.
  - Else if i_arvalid, go to AR_I.
  - Decision is registered, so m_arvalid rises one cycle after the request is seen.
- Address latch: on entry to AR_x, latch that requester's address and length into m_araddr/m_arlen.
  - Instruction: m_arsize = 3'b010, m_arid = 0.
  - Data: m_arsize = d_arsize, m_arid = 1.
- AR_x state:
  - m_arvalid = 1; x_arready = m_arready (combinational).
  - On m_arvalid && m_arready, go to R_x.
  - m_arvalid is held until the handshake; the latched fields stay stable.
- R_x state:
  - m_rready = x_rready; x_rvalid = m_rvalid; the other side's rvalid = 0.
  - On m_rvalid && m_rready && m_rlast, go to IDLE.
  - The next grant is possible in the following cycle; there is no back-to-back AR in the rlast cycle.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) each cycle the FSM is in IDLE with i_arvalid and the data side wins.
  - Clears when an instruction AR handshake completes.
  - Holds otherwise.
- wr_cnt:
  - +1 on m_awvalid && m_awready; -1 on m_bvalid && m_bready.
  - Both in the same cycle: unchanged.
  - Saturates at all-ones and never underflows below 0; each boundary is a verification assertion.
- Requester obligations: requesters hold x_arvalid and payload until x_arready.
  - A requester dropping arvalid while in AR_x is a protocol violation; the FSM still completes the latched request.
- busy = 1 in every state except IDLE.

Test Plan:
1. Instruction request alone: i_arvalid, addr 0xBFC0_0000, arlen 7, m_arready=1, 8 R beats -> m_arvalid at cycle+1, m_arid=0, m_arsize=2, i_rvalid on all 8 beats, IDLE after rlast, busy high throughout.
2. Simultaneous i_arvalid and d_arvalid, wr_cnt=0 -> data granted first (m_arid=1, d_arsize passed through); instruction granted immediately after the data rlast.
3. Data requests held continuously with instruction pending, STARVE_LIMIT=8 -> after 8 data wins the instruction is granted; starve_cnt reads 0 after its AR handshake.
4. One AW handshake then d_arvalid -> data held off and instruction served if pending; data AR issued the cycle after the B handshake returns wr_cnt to 0.
5. AW and B handshakes in the same cycle with wr_cnt=1 -> wr_cnt stays 1 and data remains blocked.
6. rst asserted during R_D beat 3 of 8 -> next cycle state IDLE, all outputs 0, wr_cnt 0; a new instruction request is granted normally afterwards.
